// File: rtl/snoop_arb.sv
// Snooper-to-core arbiter: round-robin grant of the snooper's write stream to one ready core.
// Optional statistics counters are built when SNOOP_ARB_STATS_EN is defined.
module snoop_arb #(
  parameter int N                 = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SN_FWD_ADDR_WIDTH-1:0] addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_en,
  input  logic [INC_WIDTH-1:0]         byte_inc,
  input  logic                         done,
  output logic                         rdy,
  input  logic                         ack,
  output logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  output logic [INC_WIDTH-1:0]         sn_byte_inc,
  output logic [N-1:0]                 sn_wr_en,
  output logic [N-1:0]                 sn_done,
  input  logic [N-1:0]                 rdy_for_sn,
  output logic [N-1:0]                 rdy_for_sn_ack
`ifdef SNOOP_ARB_STATS_EN
  ,
  output logic [31:0]                  grant_cnt,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   last;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W-1:0]   hi_idx;
  logic [SEL_W-1:0]   lo_idx;
  logic               hi_found;
  logic               sel_vld;
  logic               grant;

  // Handshake: rdy is a pure OR of core readiness; a grant happens in any
  // cycle where rdy && ack, and the chosen core sees its ack bit that cycle.
  assign rdy     = |rdy_for_sn;
  assign grant   = rdy && ack;
  assign sel_vld = (state == BUSY);

  assign sn_addr     = addr;
  assign sn_wr_data  = wr_data;
  assign sn_byte_inc = byte_inc;

  // Round-robin: lowest ready index above last, else lowest ready index overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rdy_for_sn[i]) begin
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end else begin
          lo_idx = SEL_W'(i);
        end
      end
    end
    cand = hi_found ? hi_idx : lo_idx;
  end

  // Ack is masked by reset so every per-core output is quiet while rst is low.
  always_comb begin
    rdy_for_sn_ack = '0;
    sn_wr_en       = '0;
    sn_done        = '0;
    for (int i = 0; i < N; i++) begin
      rdy_for_sn_ack[i] = rst && grant && (cand == SEL_W'(i));
      sn_wr_en[i]       = wr_en && sel_vld && (sel == SEL_W'(i));
      sn_done[i]        = done && sel_vld && (sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      last  <= SEL_W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= BUSY;
            sel   <= cand;
            last  <= cand;
          end
        end
        BUSY: begin
          // A new grant outranks a simultaneous done; done still reaches the old core.
          if (grant) begin
            sel  <= cand;
            last <= cand;
          end else if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNOOP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (grant && (grant_cnt != '1)) grant_cnt <= grant_cnt + 32'd1;
      if (wr_en && !sel_vld && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/snoop_arb.md
SNOOP_ARB -- requirements
Module: snoop_arb

Interface
REQ-001 Parameter N, default 4: number of packetfilter_cores served.
REQ-002 Parameter SN_FWD_ADDR_WIDTH, default 8: packet memory address width.
REQ-003 Parameter SN_FWD_DATA_WIDTH, default 64: packet memory write data width.
REQ-004 Parameter INC_WIDTH, default 8: byte-length increment width.
REQ-005 Ports SHALL be, in this order (name, direction, width, meaning):
- clk, in, 1: sole clock; all state on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- addr, in, SN_FWD_ADDR_WIDTH: snooper write address.
- wr_data, in, SN_FWD_DATA_WIDTH: snooper write data.
- wr_en, in, 1: snooper write strobe.
- byte_inc, in, INC_WIDTH: bytes added by this write.
- done, in, 1: snooper finished current packet.
- rdy, out, 1: some core can accept a packet.
- ack, in, 1: snooper accepts grant.
- sn_addr, out, SN_FWD_ADDR_WIDTH: broadcast address.
- sn_wr_data, out, SN_FWD_DATA_WIDTH: broadcast data.
- sn_byte_inc, out, INC_WIDTH: broadcast increment.
- sn_wr_en, out, N: gated write strobes.
- sn_done, out, N: gated done strobes.
- rdy_for_sn, in, N: core i has an empty buffer.
- rdy_for_sn_ack, out, N: one-hot grant acknowledge to cores.
- (STATS only) grant_cnt, out, 32; drop_cnt, out, 16.

Function
REQ-006 Two states: IDLE (no core selected, sel_vld=0) and BUSY (core sel selected, sel_vld=1).
REQ-007 rdy SHALL be combinational OR of rdy_for_sn, in both states.
REQ-008 Candidate SHALL be the first set bit of rdy_for_sn searched round-robin from last+1 modulo N.
REQ-009 On rdy&&ack, rdy_for_sn_ack[candidate] SHALL be 1 in that same cycle; all other bits 0; ack bits 0 otherwise.
REQ-010 On rdy&&ack, next edge: sel<=candidate, last<=candidate, sel_vld<=1 (enter/stay BUSY).
REQ-011 ack with rdy=0 SHALL be ignored; no state change.
REQ-012 sn_addr, sn_wr_data, sn_byte_inc SHALL equal addr, wr_data, byte_inc combinationally.
REQ-013 sn_wr_en[i] = wr_en && sel_vld && sel==i; sn_done[i] = done && sel_vld && sel==i; zero latency.
REQ-014 done in BUSY without simultaneous grant: next edge sel_vld<=0 (IDLE).
REQ-015 done and rdy&&ack in the same cycle: done goes to old sel; new grant wins, state BUSY with new sel.
REQ-016 wr_en or done in IDLE: SHALL be dropped (no sn_wr_en/sn_done bit set).
REQ-017 Grant while BUSY without done: sel SHALL switch to new candidate; old core receives no done.
REQ-018 Core i dropping rdy_for_sn[i] while selected SHALL NOT affect sel or gating.

Reset
REQ-019 While rst=0: sel_vld=0, sel=0, last=N-1 (first grant to lowest ready index), counters 0; all N-bit outputs 0.
REQ-020 Reset mid-packet SHALL immediately force sn_wr_en and sn_done to 0; no done issued.
REQ-021 Reset release SHALL act on first rising edge with rst=1.

Configuration
REQ-022 Macro SNOOP_ARB_STATS_EN: when defined, grant_cnt counts rdy&&ack events and drop_cnt counts wr_en cycles in IDLE; both saturate at all-ones.
REQ-023 Without SNOOP_ARB_STATS_EN: grant_cnt and drop_cnt ports SHALL NOT exist; function otherwise identical.

Verification (N=4)
REQ-024 Reset, rdy_for_sn=4'b1010, ack=1 one cycle -> rdy_for_sn_ack=4'b0010 that cycle; sel=1 next.
REQ-025 BUSY sel=1, wr_en=1 addr=8'h05 for 3 cycles -> sn_wr_en=4'b0010 each cycle, sn_addr=8'h05; done=1 -> sn_done=4'b0010, then IDLE.
REQ-026 last=1, rdy_for_sn=4'b1111, ack -> grant to core 2; repeat ack -> 3, then 0 (wrap).
REQ-027 BUSY sel=2, done and ack same cycle with rdy_for_sn=4'b1001 -> sn_done=4'b0100, rdy_for_sn_ack=4'b1000, sel=3 next.
REQ-028 IDLE, wr_en=1 for 5 cycles -> sn_wr_en=0; with SNOOP_ARB_STATS_EN drop_cnt=5.
REQ-029 BUSY, wr_en=1, rst=0 asynchronously mid-cycle -> sn_wr_en=0 immediately; after release rdy reflects rdy_for_sn, sel_vld=0.
